// File: rtl/cutthrough_filter_v2.sv
// Cut-through key filter: forwards packets whose head-beat key matches any enabled slot, drops others.
// Optional packet statistics are compiled in when CTF_STATS_EN is defined.
module cutthrough_filter_v2 #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned NUM_KEYS = 4,
  parameter int unsigned KEY_LSB  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     slave_tdata,
  input  logic [DATA_W/8-1:0]   slave_byteEnable,
  input  logic                  slave_tvalid,
  input  logic                  slave_tlast,
  output logic                  slave_tready,
  output logic [DATA_W-1:0]     master_tdata,
  output logic [DATA_W/8-1:0]   master_byteEnable,
  output logic                  master_tvalid,
  output logic                  master_tlast,
  input  logic                  master_tready,
  input  logic [NUM_KEYS*32-1:0] cfg_key,
  input  logic [NUM_KEYS-1:0]   cfg_key_valid
`ifdef CTF_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [31:0]           stat_fwd_pkts,
  output logic [31:0]           stat_drop_pkts
`endif
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned KEY_BE = KEY_LSB / 8;

  localparam logic [1:0] ST_HEAD = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              tready_q;

  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [BE_W-1:0]   out_be_q, out_be_d;

  logic              skid_valid_q, skid_valid_d;
  logic              skid_last_q, skid_last_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [BE_W-1:0]   skid_be_q, skid_be_d;

  logic key_hit, match, accept, is_head, fwd_beat, out_ready;

  always_comb begin
    key_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (cfg_key_valid[i] && (slave_tdata[KEY_LSB +: 32] == cfg_key[32*i +: 32])) begin
        key_hit = 1'b1;
      end
    end
    // A partially-enabled key field can never match.
    match = key_hit & (&slave_byteEnable[KEY_BE +: 4]);
  end

  assign accept    = slave_tvalid & tready_q;
  assign is_head   = (state_q == ST_HEAD);
  assign fwd_beat  = accept & ((state_q == ST_FWD) | (is_head & match));
  assign out_ready = ~out_valid_q | master_tready;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (slave_tlast) begin
        state_d = ST_HEAD;
      end else if (is_head) begin
        state_d = match ? ST_FWD : ST_DROP;
      end
    end
  end

  // Skid only fills while tready is high, so it is never loaded while it is already full.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_data_d   = out_data_q;
    out_be_d     = out_be_q;
    skid_valid_d = skid_valid_q;
    skid_last_d  = skid_last_q;
    skid_data_d  = skid_data_q;
    skid_be_d    = skid_be_q;
    if (out_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_last_d   = skid_last_q;
        out_data_d   = skid_data_q;
        out_be_d     = skid_be_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = fwd_beat;
        if (fwd_beat) begin
          out_last_d = slave_tlast;
          out_data_d = slave_tdata;
          out_be_d   = slave_byteEnable;
        end
      end
    end else if (fwd_beat) begin
      skid_valid_d = 1'b1;
      skid_last_d  = slave_tlast;
      skid_data_d  = slave_tdata;
      skid_be_d    = slave_byteEnable;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_HEAD;
      tready_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      out_be_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_be_q    <= '0;
    end else begin
      state_q      <= state_d;
      tready_q     <= ~skid_valid_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      out_be_q     <= out_be_d;
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
      skid_data_q  <= skid_data_d;
      skid_be_q    <= skid_be_d;
    end
  end

  assign slave_tready      = tready_q;
  assign master_tvalid     = out_valid_q;
  assign master_tlast      = out_last_q;
  assign master_tdata      = out_data_q;
  assign master_byteEnable = out_be_q;

`ifdef CTF_STATS_EN
  logic [31:0] fwd_cnt_q, drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst || stat_clr) begin
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else if (accept && is_head) begin
      if (match) fwd_cnt_q  <= fwd_cnt_q + 32'd1;
      else       drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign stat_fwd_pkts  = fwd_cnt_q;
  assign stat_drop_pkts = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cutthrough_filter_v2.sv
// Directed self-checking bench for cutthrough_filter_v2 (default parameters).
module tb_cutthrough_filter_v2;

  localparam logic [31:0] KEY0    = 32'h474F4F47;
  localparam logic [31:0] KEY_BAD = 32'h4D534654;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  slave_tdata;
  logic [7:0]   slave_byteEnable;
  logic         slave_tvalid;
  logic         slave_tlast;
  logic         slave_tready;
  logic [63:0]  master_tdata;
  logic [7:0]   master_byteEnable;
  logic         master_tvalid;
  logic         master_tlast;
  logic         master_tready;
  logic [127:0] cfg_key;
  logic [3:0]   cfg_key_valid;
`ifdef CTF_STATS_EN
  logic         stat_clr;
  logic [31:0]  stat_fwd_pkts;
  logic [31:0]  stat_drop_pkts;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] q_data[$];
  logic        q_last[$];

  always #5 clk = ~clk;

  cutthrough_filter_v2 dut (
    .clk              (clk),
    .rst              (rst),
    .slave_tdata      (slave_tdata),
    .slave_byteEnable (slave_byteEnable),
    .slave_tvalid     (slave_tvalid),
    .slave_tlast      (slave_tlast),
    .slave_tready     (slave_tready),
    .master_tdata     (master_tdata),
    .master_byteEnable(master_byteEnable),
    .master_tvalid    (master_tvalid),
    .master_tlast     (master_tlast),
    .master_tready    (master_tready),
    .cfg_key          (cfg_key),
    .cfg_key_valid    (cfg_key_valid)
`ifdef CTF_STATS_EN
    ,
    .stat_clr         (stat_clr),
    .stat_fwd_pkts    (stat_fwd_pkts),
    .stat_drop_pkts   (stat_drop_pkts)
`endif
  );

  // Inputs change just after posedge, so a negedge sample reflects the next edge's handshake.
  always @(negedge clk) begin
    if (master_tvalid && master_tready) begin
      q_data.push_back(master_tdata);
      q_last.push_back(master_tlast);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] be, input logic last);
    slave_tdata      = d;
    slave_byteEnable = be;
    slave_tlast      = last;
    slave_tvalid     = 1'b1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (slave_tready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    check_eq("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    slave_tvalid = 1'b0;
    slave_tlast  = 1'b0;
  endtask

  task automatic settle();
    idle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] head(input logic [31:0] key, input logic [23:0] tag);
    return {8'd0, key, tag};
  endfunction

  initial begin
    rst              = 1'b0;
    slave_tdata      = '0;
    slave_byteEnable = '0;
    slave_tvalid     = 1'b0;
    slave_tlast      = 1'b0;
    master_tready    = 1'b1;
    cfg_key          = {96'd0, KEY0};
    cfg_key_valid    = 4'b0001;
`ifdef CTF_STATS_EN
    stat_clr         = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tready", {63'd0, slave_tready}, 64'd0);
    check_eq("rst_tvalid", {63'd0, master_tvalid}, 64'd0);
    check_eq("rst_tlast", {63'd0, master_tlast}, 64'd0);
    check_eq("rst_tdata", master_tdata, 64'd0);
    check_eq("rst_be", {56'd0, master_byteEnable}, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_tready", {63'd0, slave_tready}, 64'd1);

    // Matching 3-beat packet, one cycle latency per beat
    send(head(KEY0, 24'd0), 8'hFF, 1'b0);
    check_eq("t1_lat_head_v", {63'd0, master_tvalid}, 64'd1);
    check_eq("t1_lat_head_d", master_tdata, head(KEY0, 24'd0));
    send(64'h12345678, 8'hFF, 1'b0);
    check_eq("t1_lat_b1_d", master_tdata, 64'h12345678);
    send(64'h876654321, 8'hFF, 1'b1);
    check_eq("t1_lat_b2_d", master_tdata, 64'h876654321);
    check_eq("t1_lat_b2_last", {63'd0, master_tlast}, 64'd1);
    settle();
    check_eq("t1_count", 64'(q_data.size()), 64'd3);
    if (q_data.size() == 3) begin
      check_eq("t1_d0", q_data[0], head(KEY0, 24'd0));
      check_eq("t1_d2", q_data[2], 64'h876654321);
      check_eq("t1_last0", {63'd0, q_last[0]}, 64'd0);
      check_eq("t1_last2", {63'd0, q_last[2]}, 64'd1);
    end
    q_data.delete();
    q_last.delete();

    // Non-matching packet with downstream stalled: dropped, tready stays high
    master_tready = 1'b0;
    send(head(KEY_BAD, 24'd0), 8'hFF, 1'b0);
    check_eq("t2_tready0", {63'd0, slave_tready}, 64'd1);
    send(64'h12345678, 8'hFF, 1'b0);
    check_eq("t2_tready1", {63'd0, slave_tready}, 64'd1);
    send(64'h876654321, 8'hFF, 1'b1);
    check_eq("t2_tready2", {63'd0, slave_tready}, 64'd1);
    check_eq("t2_tvalid", {63'd0, master_tvalid}, 64'd0);
    settle();
    check_eq("t2_count", 64'(q_data.size()), 64'd0);

    // Matching packet, downstream stalled for 4 cycles: skid fills and backpressures
    fork
      begin
        send(head(KEY0, 24'd3), 8'hFF, 1'b0);
        send(64'hA1, 8'hFF, 1'b0);
        check_eq("t3_tready_fall", {63'd0, slave_tready}, 64'd0);
        send(64'hA2, 8'hFF, 1'b1);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        master_tready = 1'b1;
      end
    join
    settle();
    check_eq("t3_count", 64'(q_data.size()), 64'd3);
    if (q_data.size() == 3) begin
      check_eq("t3_d0", q_data[0], head(KEY0, 24'd3));
      check_eq("t3_d1", q_data[1], 64'hA1);
      check_eq("t3_d2", q_data[2], 64'hA2);
      check_eq("t3_last2", {63'd0, q_last[2]}, 64'd1);
    end
    q_data.delete();
    q_last.delete();

    // Alternating single-beat match/drop, back-to-back; two slots hold the same key
    cfg_key       = {64'd0, KEY0, KEY0};
    cfg_key_valid = 4'b0011;
`ifdef CTF_STATS_EN
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      send(head((i % 2 == 0) ? KEY0 : KEY_BAD, 24'(i)), 8'hFF, 1'b1);
    end
    settle();
    check_eq("t4_count", 64'(q_data.size()), 64'd4);
    if (q_data.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check_eq("t4_data", q_data[i], head(KEY0, 24'(2 * i)));
      end
    end
`ifdef CTF_STATS_EN
    check_eq("t4_stat_fwd", {32'd0, stat_fwd_pkts}, 64'd4);
    check_eq("t4_stat_drop", {32'd0, stat_drop_pkts}, 64'd4);
`endif
    q_data.delete();
    q_last.delete();
    cfg_key_valid = 4'b0001;

    // Key byte 0 (byte lane 3) disabled: packet dropped
    send(head(KEY0, 24'd5), 8'hF7, 1'b0);
    send(64'hB1, 8'hFF, 1'b1);
    settle();
    check_eq("t5_count", 64'(q_data.size()), 64'd0);

    // All slots disabled: matching key still dropped
    cfg_key_valid = 4'b0000;
    send(head(KEY0, 24'd6), 8'hFF, 1'b1);
    settle();
    check_eq("t5b_count", 64'(q_data.size()), 64'd0);
    cfg_key_valid = 4'b0001;

    // Reset during beat 2 of a forwarded packet; remainder is decided as a head
    send(head(KEY0, 24'd7), 8'hFF, 1'b0);
    slave_tdata = 64'h12345678;
    rst         = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t6_rst_tvalid", {63'd0, master_tvalid}, 64'd0);
    check_eq("t6_rst_tready", {63'd0, slave_tready}, 64'd0);
    rst = 1'b1;
    q_data.delete();
    q_last.delete();
    send(64'h876654321, 8'hFF, 1'b1);
    settle();
    check_eq("t6_remainder_dropped", 64'(q_data.size()), 64'd0);
    send(head(KEY0, 24'd8), 8'hFF, 1'b1);
    settle();
    check_eq("t6_next_head_count", 64'(q_data.size()), 64'd1);
    if (q_data.size() == 1) check_eq("t6_next_head_d", q_data[0], head(KEY0, 24'd8));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cutthrough_filter_v2.md
Name: cutthrough_filter_v2

Overview:
- Parametrised successor to the single-key cut-through filter on the market-data AXI-Stream path.
- Inspects a 32-bit key field in the head beat of each packet against NUM_KEYS programmable keys. Forwards matching packets beat-by-beat with one cycle of latency. Silently drops non-matching packets.
- Sits between the packet parser and the order-book/strategy logic.

Parameters:
- DATA_W, 64, stream data width in bits (multiple of 8, >= 32).
- NUM_KEYS, 4, number of programmable key slots (1..16).
- KEY_LSB, 24, bit position of key LSB within head beat (KEY_LSB+32 <= DATA_W, multiple of 8).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- slave_tdata  in  DATA_W  upstream data
- slave_byteEnable  in  DATA_W/8  upstream byte enables
- slave_tvalid  in  1  upstream valid
- slave_tlast  in  1  upstream end of packet
- slave_tready  out  1  ready to upstream
- master_tdata  out  DATA_W  downstream data
- master_byteEnable  out  DATA_W/8  downstream byte enables
- master_tvalid  out  1  downstream valid
- master_tlast  out  1  downstream end of packet
- master_tready  in  1  downstream ready
- cfg_key  in  NUM_KEYS*32  key table; slot i = cfg_key[32*i+:32]
- cfg_key_valid  in  NUM_KEYS  per-slot enable

Behaviour:
- Reset: clk, rst, and one clock only; reset is synchronous and active-low. While rst=0 at a clk edge: state=HEAD, master_tvalid=0, master_tlast=0, master_tdata=0, master_byteEnable=0, skid buffer empty, slave_tready=0. slave_tready=1 from the first cycle after rst returns high.
- Beat accepted = slave_tvalid & slave_tready. Beat emitted = master_tvalid & master_tready.
- Output stage: registered output plus a 1-entry skid buffer. slave_tready is a register output, equal to "skid empty".
- Latency: accepted forwarded beat appears on master_* the next cycle when the output register is free or draining.
- Master outputs stay stable while master_tvalid=1 & master_tready=0.
- FSM states:
  - HEAD: next accepted beat is a packet head. match = OR over i of (cfg_key_valid[i] & tdata[KEY_LSB+:32]==key_i & all 4 key byteEnables set). Match forwards the beat. No match drops the beat. Next state: tlast -> HEAD; else match -> FWD, else DROP.
  - FWD: every accepted beat is forwarded. Accepted tlast -> HEAD.
  - DROP: slave_tready=1 regardless of downstream state. Accepted beats are discarded. Accepted tlast -> HEAD.
- Dropped beats never assert master_tvalid and never occupy the skid buffer.
- Single-beat packet (head with tlast): decided and forwarded or dropped in that beat; FSM stays in HEAD.
- cfg_key / cfg_key_valid are sampled only on head acceptance. Changes mid-packet do not affect the current packet.
- All cfg_key_valid=0 -> every packet is dropped.
- Multiple slots matching: treated as a single match.
- slave_tvalid low mid-packet: state held, no timeout.
- Reset mid-packet: FSM returns to HEAD and in-flight output beats are discarded. The next accepted beat is treated as a head, including a mid-packet remainder from upstream.
- Back-to-back packets: a head may be accepted the cycle after the previous tlast, with no bubble.

Optional Feature:
- Macro CTF_STATS_EN.
- Defined: adds outputs stat_fwd_pkts (32b), stat_drop_pkts (32b) and input stat_clr (1b).
  - Each counter increments once per head decision (forwarded / dropped) and wraps at 2^32-1 -> 0.
  - Counters are cleared by rst or stat_clr. stat_clr wins over a simultaneous increment.
- Undefined: none of these ports or counters exist. Datapath behaviour is identical.

Test Plan:
- Key 0 = 32'h474F4F47 valid. 3-beat packet, head tdata = {8'd0,32'h474F4F47,24'd0}, then 64'h12345678, 64'h876654321 with tlast, master_tready=1 -> all 3 beats out, each 1 cycle after acceptance, tlast on the third.
- Same packet but head key 32'h4D534654, master_tready=0 throughout -> slave_tready stays 1, 0 beats out, FSM back to HEAD after tlast.
- Matching packet with master_tready low for the first 4 cycles -> slave_tready falls after skid fill. No beat lost or duplicated; order preserved.
- Alternating match/drop single-beat packets on consecutive cycles, tready=1 -> exactly the matching beats emitted. CTF_STATS_EN: fwd=drop=N/2.
- Head matches, but the head byteEnable clears one key byte -> packet dropped.
- rst low during beat 2 of a forwarded packet -> master_tvalid=0 next cycle. The next beat is decided as a head.
